// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Definitions shared by the seven-segment encoder (seg7) and the capture/decoder
//   side (seg7_capture_decoder, seg7_decode).
//   - Segment bit order on the bus: {g,f,e,d,c,b,a}, active high, a in bit 0.
//   - SEG_0..SEG_9: the ten legal digit patterns; BLANK: all segments off.
//   - seg_code(): digit -> pattern lookup (digits above 9 return BLANK).
package seg7_pkg;

    localparam int SEG_W = 7;

    // Bit positions within the segment bus
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [SEG_W-1:0] BLANK = 7'h00;
    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;

    function automatic logic [SEG_W-1:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = SEG_0;
            4'd1:    seg_code = SEG_1;
            4'd2:    seg_code = SEG_2;
            4'd3:    seg_code = SEG_3;
            4'd4:    seg_code = SEG_4;
            4'd5:    seg_code = SEG_5;
            4'd6:    seg_code = SEG_6;
            4'd7:    seg_code = SEG_7;
            4'd8:    seg_code = SEG_8;
            4'd9:    seg_code = SEG_9;
            default: seg_code = BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
//   Combinational seven-segment to BCD decoder. Only exact matches against the
//   ten legal digit patterns are legal; anything else (including BLANK and
//   patterns with extra or missing segments) is reported as illegal.
// Ports
//   seg    in  7  segment pattern {g,f,e,d,c,b,a}
//   legal  out 1  pattern is one of SEG_0..SEG_9
//   digit  out 4  decoded digit, 0 when not legal
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic             legal,
    output logic [3:0]       digit
);

    logic [9:0] hit;

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_match
            assign hit[gi] = (seg == seg_code(4'(gi)));
        end
    endgenerate

    // The legal codes are distinct, so at most one hit bit is set and OR-ing
    // the matching indices yields the digit without a priority chain.
    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (hit[i]) begin
                digit = digit | 4'(i);
            end
        end
    end

    assign legal = |hit;

endmodule

// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder
//   Receive side of the seven-segment digit link. Synchronises the asynchronous
//   segment bus, requires a pattern to be stable for STABLE_CYCLES samples before
//   accepting it, decodes it to BCD, checks the +1 mod 10 sequence and measures
//   the clock count between consecutive digit steps.
// Ports
//   clk           in   1         clock
//   reset         in   1         synchronous active-high reset
//   seg_in        in   7         raw segment bus {g,f,e,d,c,b,a}, asynchronous
//   digit         out  4         last valid decoded digit
//   digit_valid   out  1         accepted pattern decodes to a legal digit
//   step          out  1         pulse: new legal pattern accepted
//   bad_pattern   out  1         pulse: non-digit pattern accepted
//   seq_error     out  1         pulse with step: digit broke the +1 mod 10 sequence
//   period        out  PERIOD_W  cycles between the last two steps, saturating
//   period_valid  out  1         sticky: at least two steps since reset
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SEG_W-1:0]    seg_in,
    output logic [3:0]          digit,
    output logic                digit_valid,
    output logic                step,
    output logic                bad_pattern,
    output logic                seq_error,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid
);

    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0]    s1_reg;
    logic [SEG_W-1:0]    s2_reg;
    logic [SEG_W-1:0]    cand_reg;
    logic [SEG_W-1:0]    acc_reg;
    logic [7:0]          stab_cnt_reg;
    logic                have_prev_reg;
    logic [PERIOD_W-1:0] pcnt_reg;

    logic                dec_legal;
    logic [3:0]          dec_digit;
    logic [3:0]          next_digit;
    logic [PERIOD_W-1:0] pcnt_next;

    // The candidate is what gets accepted, so decode it directly.
    seg7_decode u_decode (
        .seg   (cand_reg),
        .legal (dec_legal),
        .digit (dec_digit)
    );

    assign next_digit = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    assign pcnt_next  = (&pcnt_reg) ? pcnt_reg : pcnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg        <= '0;
            s2_reg        <= '0;
            cand_reg      <= BLANK;
            acc_reg       <= BLANK;
            stab_cnt_reg  <= '0;
            have_prev_reg <= 1'b0;
            pcnt_reg      <= '0;
            digit         <= '0;
            digit_valid   <= 1'b0;
            step          <= 1'b0;
            bad_pattern   <= 1'b0;
            seq_error     <= 1'b0;
            period        <= '0;
            period_valid  <= 1'b0;
        end else begin
            s1_reg      <= seg_in;
            s2_reg      <= s1_reg;
            step        <= 1'b0;
            bad_pattern <= 1'b0;
            seq_error   <= 1'b0;
            pcnt_reg    <= pcnt_next;

            if (s2_reg != cand_reg) begin
                cand_reg     <= s2_reg;
                stab_cnt_reg <= '0;
            end else if (stab_cnt_reg < STAB_LAST) begin
                stab_cnt_reg <= stab_cnt_reg + 8'd1;
            end else if (cand_reg != acc_reg) begin
                // Counter stays at its terminal value; the accepted/candidate
                // equality is what stops a second accept of the same pattern.
                acc_reg <= cand_reg;
                if (dec_legal) begin
                    digit         <= dec_digit;
                    digit_valid   <= 1'b1;
                    step          <= 1'b1;
                    seq_error     <= have_prev_reg && (dec_digit != next_digit);
                    have_prev_reg <= 1'b1;
                    if (have_prev_reg) begin
                        period       <= pcnt_next;
                        period_valid <= 1'b1;
                    end
                    pcnt_reg <= '0;
                end else begin
                    // Digit and period tracking are left untouched so the next
                    // legal digit is checked against the last good one.
                    digit_valid <= 1'b0;
                    bad_pattern <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// tb_seg7_capture_decoder
//   Bench for seg7_capture_decoder: directed table of held patterns with
//   expected pulse counts and end state, hand-written latency / saturation /
//   mid-run reset sequences, and randomised segment streams checked every cycle
//   against a run-length based reference model.
module tb_seg7_capture_decoder;

    localparam int STABLE = 4;
    localparam int PW     = 12;          // narrow period counter so saturation is reachable quickly
    localparam int MAXP   = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    seg_in = 7'h00;
    logic [3:0]    digit;
    logic          digit_valid;
    logic          step;
    logic          bad_pattern;
    logic          seq_error;
    logic [PW-1:0] period;
    logic          period_valid;

    always #5 clk = ~clk;

    seg7_capture_decoder #(
        .STABLE_CYCLES (STABLE),
        .PERIOD_W      (PW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .seg_in       (seg_in),
        .digit        (digit),
        .digit_valid  (digit_valid),
        .step         (step),
        .bad_pattern  (bad_pattern),
        .seq_error    (seq_error),
        .period       (period),
        .period_valid (period_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic int dec_of(input logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (codes[i] == p) return i;
        end
        return -1;
    endfunction

    // ---------------- reference model ----------------
    // Tracks how many consecutive edges the synchronised value has been the
    // same; a pattern is taken once that run reaches STABLE+1 edges and it is
    // not already the accepted one. Period is the edge-index difference.
    bit          m_en = 1'b0;
    logic [6:0]  m_s1, m_s2, m_val, m_acc;
    int          m_run;
    int          m_digit;
    bit          m_dv, m_step, m_bad, m_seq, m_hp, m_pv;
    longint      m_period, m_edge, m_last;

    always @(posedge clk) begin
        int d;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_val = 0; m_acc = 0; m_run = 1;
            m_digit = 0; m_dv = 0; m_step = 0; m_bad = 0; m_seq = 0;
            m_hp = 0; m_pv = 0; m_period = 0; m_edge = 0; m_last = 0;
        end else begin
            m_edge++;
            if (m_s2 == m_val) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_val = m_s2;
                m_run = 1;
            end
            m_s2 = m_s1;
            m_s1 = seg_in;
            m_step = 0; m_bad = 0; m_seq = 0;
            if (m_run >= STABLE + 1 && m_val != m_acc) begin
                m_acc = m_val;
                d = dec_of(m_val);
                if (d >= 0) begin
                    m_seq  = m_hp && (d != (m_digit + 1) % 10);
                    m_step = 1;
                    m_dv   = 1;
                    if (m_hp) begin
                        m_period = (m_edge - m_last > MAXP) ? MAXP : m_edge - m_last;
                        m_pv = 1;
                    end
                    m_last  = m_edge;
                    m_hp    = 1;
                    m_digit = d;
                end else begin
                    m_dv  = 0;
                    m_bad = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            check("model", {11'd0, digit, digit_valid, step, bad_pattern, seq_error, period, period_valid},
                  {11'd0, m_digit[3:0], m_dv, m_step, m_bad, m_seq, m_period[PW-1:0], m_pv});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic run_seg(input logic [6:0] pat, input int n, output int ns, output int nb, output int nq);
        ns = 0; nb = 0; nq = 0;
        seg_in = pat;
        repeat (n) begin
            @(negedge clk);
            ns += int'(step);
            nb += int'(bad_pattern);
            nq += int'(seq_error);
        end
    endtask

    typedef struct {
        logic [6:0] pat;
        int         hold;
        int         steps;
        int         bads;
        int         seqs;
        int         dig;
        int         valid;
        int         per;
        int         pv;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int ns, nb, nq;
        logic [6:0] pat;
        int hold, r, k;

        // table: pattern, hold, steps, bads, seq_errors, digit, valid, period, period_valid
        for (int d = 1; d <= 9; d++) tbl.push_back('{codes[d], 100, 1, 0, 0, d, 1, 100, 1});
        tbl.push_back('{7'h3F, 100, 1, 0, 0, 0, 1, 100, 1});
        tbl.push_back('{7'h06,  20, 1, 0, 0, 1, 1, 100, 1});
        tbl.push_back('{7'h5B,  20, 1, 0, 0, 2, 1,  20, 1});
        tbl.push_back('{7'h66,  20, 1, 0, 1, 4, 1,  20, 1});
        tbl.push_back('{7'h6D,  20, 1, 0, 0, 5, 1,  20, 1});
        tbl.push_back('{7'h7F,   3, 0, 0, 0, 5, 1,  20, 1});
        tbl.push_back('{7'h6D,  20, 0, 0, 0, 5, 1,  20, 1});
        tbl.push_back('{7'h7D,  20, 1, 0, 0, 6, 1,  43, 1});
        tbl.push_back('{7'h07,  20, 1, 0, 0, 7, 1,  20, 1});
        tbl.push_back('{7'h00,  20, 0, 1, 0, 7, 0,  20, 1});
        tbl.push_back('{7'h7F,  20, 1, 0, 0, 8, 1,  40, 1});

        // reset state
        reset = 1'b1;
        seg_in = 7'h00;
        repeat (3) @(negedge clk);
        m_en = 1'b1;
        check("reset_outputs", {11'd0, digit, digit_valid, step, bad_pattern, seq_error, period, period_valid}, 32'd0);

        // first digit: accept lands 6 edges after the first sampling edge (7th negedge)
        reset = 1'b0;
        seg_in = 7'h3F;
        ns = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i <= 10) check("first_step_timing", {31'd0, step}, {31'd0, (i == 7)});
            ns += int'(step);
            if (i == 7) check("first_seq_error", {31'd0, seq_error}, 32'd0);
        end
        check("first_steps", ns, 1);
        check("first_digit", digit, 0);
        check("first_valid", digit_valid, 1);
        check("first_pv", period_valid, 0);
        $display("first digit: steps=%0d digit=%0d valid=%0d", ns, digit, digit_valid);

        foreach (tbl[i]) begin
            run_seg(tbl[i].pat, tbl[i].hold, ns, nb, nq);
            check("tbl_steps", ns, tbl[i].steps);
            check("tbl_bads", nb, tbl[i].bads);
            check("tbl_seqs", nq, tbl[i].seqs);
            check("tbl_digit", digit, tbl[i].dig);
            check("tbl_valid", digit_valid, tbl[i].valid);
            check("tbl_period", period, tbl[i].per);
            check("tbl_pv", period_valid, tbl[i].pv);
            $display("row %0d: pat=%02h hold=%0d steps=%0d bads=%0d seqs=%0d digit=%0d valid=%0d period=%0d",
                     i, tbl[i].pat, tbl[i].hold, ns, nb, nq, digit, digit_valid, period);
        end

        // saturation: steps 2^PW+5 cycles apart
        run_seg(7'h4F, (1 << PW) + 5, ns, nb, nq);
        check("sat_first_step", ns, 1);
        run_seg(7'h66, 10, ns, nb, nq);
        check("sat_step", ns, 1);
        check("sat_period", period, MAXP);
        check("sat_digit", digit, 4);
        $display("saturation: steps=%0d period=%0h digit=%0d", ns, period, digit);

        // mid-run reset
        reset = 1'b1;
        @(negedge clk);
        check("midreset_outputs", {11'd0, digit, digit_valid, step, bad_pattern, seq_error, period, period_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("midreset_step_timing", {31'd0, step}, {31'd0, (i == 7)});
            if (i == 7) begin
                check("midreset_seq_error", {31'd0, seq_error}, 32'd0);
                check("midreset_digit", digit, 4);
            end
        end
        check("midreset_pv", period_valid, 0);
        $display("mid-run reset: digit=%0d valid=%0d pv=%0d", digit, digit_valid, period_valid);

        // randomised segment stream, checked every cycle by the model
        for (int s = 0; s < 250; s++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                $display("rand %0d: reset pulse", s);
                continue;
            end else if (r < 55) begin
                k = (m_digit + 1) % 10;
                pat = codes[k];
            end else if (r < 70) begin
                pat = 7'($urandom);
            end else begin
                k = $urandom_range(0, 9);
                pat = codes[k];
            end
            hold = $urandom_range(1, 12);
            run_seg(pat, hold, ns, nb, nq);
            $display("rand %0d: pat=%02h hold=%0d steps=%0d bads=%0d seqs=%0d digit=%0d period=%0d",
                     s, pat, hold, ns, nb, nq, digit, period);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
